// File: rtl/cpu_pkg.sv
// Shared SM83 core definitions: bus sequencer state, bus default constants, flag bit positions.
// No logic; types, constants and a width helper only.
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [0:0] {
        BusRun  = 1'b0,
        BusWait = 1'b1
    } bus_state_e;

    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [7:0]  OPEN_BUS = 8'hFF;

    // Bit positions of the flags in register F
    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/cpu_bus_unit_if.sv
// CPU-side request and system-bus signals of the bus sequencer.
// Latency: n/a (wires only).
// Backpressure: mem_ready low stretches the access; the CPU side waits for m_tick.
interface cpu_bus_unit_if #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int T_CYCLES = 4
);
    localparam int TW = cpu_pkg::clog2_min1(T_CYCLES);

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic [TW-1:0]     t_cycle;
    logic              clk_phi;
    logic              m_tick;
    logic              bus_err;
    logic              dma_active;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_enable;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_ready;

    modport master (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, dma_active, mem_data_in, mem_ready,
        output cpu_rdata, t_cycle, clk_phi, m_tick, bus_err,
        output mem_addr, mem_enable, mem_write, mem_data_out
    );

    modport slave (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, dma_active, mem_data_in, mem_ready,
        input  cpu_rdata, t_cycle, clk_phi, m_tick, bus_err,
        input  mem_addr, mem_enable, mem_write, mem_data_out
    );

endinterface

// File: rtl/cpu_bus_unit.sv
// SM83 memory-bus sequencer: T/M-cycle timing, wait states with timeout, DMA blocking outside HRAM.
// Latency: T_CYCLES clocks per M-cycle, plus one per wait clock, at most T_CYCLES + MAX_WAIT.
// Backpressure: mem_ready low at the last T-cycle holds t and extends the access until ready or timeout.
module cpu_bus_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                T_CYCLES = 4,
    parameter int                MAX_WAIT = 7,
    parameter logic [ADDR_W-1:0] HRAM_LO  = cpu_pkg::HRAM_LO,
    parameter logic [ADDR_W-1:0] HRAM_HI  = cpu_pkg::HRAM_HI,
    parameter logic [DATA_W-1:0] OPEN_BUS = cpu_pkg::OPEN_BUS
) (
    input  logic          clk,
    input  logic          reset,
    cpu_bus_unit_if.master bus
);

    localparam int            TW      = clog2_min1(T_CYCLES);
    localparam int            WW      = clog2_min1(MAX_WAIT + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(T_CYCLES - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(T_CYCLES / 2);
    localparam logic [WW-1:0] W_LAST  = WW'(MAX_WAIT);
    localparam bit            WAIT_EN = (MAX_WAIT > 0);

    bus_state_e        state;
    logic [TW-1:0]     t;
    logic [WW-1:0]     wait_cnt;
    logic              req_q;
    logic              write_q;
    logic              blocked_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic at_start;
    logic at_last;
    logic live_blocked;
    logic cur_req;
    logic cur_blocked;
    logic access;
    logic enter_wait;
    logic timeout;
    logic stay_wait;
    logic tick;

    assign at_start     = (t == '0);
    assign at_last      = (t == T_LAST);
    assign live_blocked = bus.dma_active &&
                          !((bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI));

    // The t==0 clock drives from the live inputs being captured; later clocks use the captured copy.
    assign cur_req     = at_start ? bus.cpu_req  : req_q;
    assign cur_blocked = at_start ? live_blocked : blocked_q;
    assign access      = cur_req && !cur_blocked;

    assign enter_wait = WAIT_EN && (state == BusRun) && at_last && access && !bus.mem_ready;
    assign timeout    = (state == BusWait) && !bus.mem_ready && (wait_cnt == W_LAST);
    assign stay_wait  = (state == BusWait) && !bus.mem_ready && !timeout;
    assign tick       = !reset && at_last && !enter_wait && !stay_wait;

    assign bus.t_cycle      = t;
    assign bus.clk_phi      = (t < T_HALF);
    assign bus.m_tick       = tick;
    assign bus.bus_err      = tick && timeout;
    assign bus.mem_enable   = access;
    assign bus.mem_write    = req_q && !blocked_q && write_q && !at_start;
    assign bus.mem_addr     = (at_start && bus.cpu_req) ? bus.cpu_addr  : addr_q;
    assign bus.mem_data_out = (at_start && bus.cpu_req) ? bus.cpu_wdata : wdata_q;
    assign bus.cpu_rdata    = (tick && access && !write_q && !timeout) ? bus.mem_data_in : OPEN_BUS;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BusRun;
            t         <= '0;
            wait_cnt  <= '0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            blocked_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            if (at_start && (state == BusRun)) begin
                req_q     <= bus.cpu_req;
                write_q   <= bus.cpu_write;
                blocked_q <= live_blocked;
                if (bus.cpu_req) begin
                    addr_q  <= bus.cpu_addr;
                    wdata_q <= bus.cpu_wdata;
                end
            end

            case (state)
                BusRun: begin
                    if (at_last) begin
                        if (enter_wait) begin
                            state    <= BusWait;
                            wait_cnt <= wait_cnt + 1'b1;
                        end else begin
                            t <= '0;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                BusWait: begin
                    if (stay_wait) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        state    <= BusRun;
                        wait_cnt <= '0;
                        t        <= '0;
                    end
                end
                default: begin
                    state    <= BusRun;
                    wait_cnt <= '0;
                    t        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Self-checking bench for cpu_bus_unit: vector table with a scoreboard, plus reset-in-wait and T_CYCLES=2 sequences.
module tb_cpu_bus_unit;

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    always #5 clk = ~clk;

    cpu_bus_unit_if #(.ADDR_W(16), .DATA_W(8), .T_CYCLES(4)) bus  ();
    cpu_bus_unit_if #(.ADDR_W(16), .DATA_W(8), .T_CYCLES(2)) bus2 ();

    cpu_bus_unit #(
        .ADDR_W(16), .DATA_W(8), .T_CYCLES(4), .MAX_WAIT(7),
        .HRAM_LO(16'hFF80), .HRAM_HI(16'hFFFE), .OPEN_BUS(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    cpu_bus_unit #(
        .ADDR_W(16), .DATA_W(8), .T_CYCLES(2), .MAX_WAIT(7),
        .HRAM_LO(16'hFF80), .HRAM_HI(16'hFFFE), .OPEN_BUS(8'hFF)
    ) dut2 (
        .clk  (clk),
        .reset(reset2),
        .bus  (bus2)
    );

    typedef struct {
        string       name;
        logic        req;
        logic        write;
        logic        dma;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          ready_low;   // clocks mem_ready is held low, starting at t==3
        logic        exp_en;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat_cnt = 0;
    logic [15:0] last_addr = 16'h0000;
    logic [7:0]  last_wdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic req, input logic write, input logic dma,
                                input logic [15:0] addr, input logic [7:0] wdata, input logic [7:0] din,
                                input int ready_low, input logic exp_en, input logic [7:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.req = req; v.write = write; v.dma = dma;
        v.addr = addr; v.wdata = wdata; v.din = din; v.ready_low = ready_low;
        v.exp_en = exp_en; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        return e;
    endfunction

    // Scoreboard side: every M-cycle end is matched against the oldest pushed expectation.
    always @(negedge clk) begin
        if (reset) begin
            check("reset/m_tick", bus.m_tick, 1'b0);
            sb.delete();
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (bus.m_tick === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb/unexpected_m_tick: m_tick with no pending access (time %0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb/cpu_rdata", bus.cpu_rdata, e.rdata);
                    check("sb/bus_err", bus.bus_err, e.err);
                    check("sb/latency", lat_cnt, e.lat);
                end
                lat_cnt = 0;
            end else begin
                check("sb/bus_err_without_tick", bus.bus_err, 1'b0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bit done;
        int idx;
        done = 1'b0;
        idx  = 1;
        bus.cpu_req     = v.req;
        bus.cpu_write   = v.write;
        bus.cpu_addr    = v.addr;
        bus.cpu_wdata   = v.wdata;
        bus.dma_active  = v.dma;
        bus.mem_data_in = v.din;
        if (v.req) begin
            last_addr  = v.addr;
            last_wdata = v.wdata;
        end
        sb.push_back(mk_exp(v.exp_rdata, v.exp_err, v.exp_lat));
        while (!done && idx <= 40) begin
            bus.mem_ready = !(idx >= 4 && idx < 4 + v.ready_low);
            @(negedge clk);
            check({v.name, "/mem_enable"}, bus.mem_enable, v.exp_en);
            check({v.name, "/mem_write"}, bus.mem_write, v.exp_en && v.write && (idx >= 2));
            check({v.name, "/t_cycle"}, bus.t_cycle, (idx < 4) ? idx - 1 : 3);
            check({v.name, "/mem_addr"}, bus.mem_addr, last_addr);
            check({v.name, "/mem_data_out"}, bus.mem_data_out, last_wdata);
            done = (bus.m_tick === 1'b1);
            @(posedge clk);
            #1;
            if (idx == 1) begin
                // Everything after t==0 must be ignored, including a DMA change.
                bus.cpu_req    = 1'($urandom);
                bus.cpu_write  = 1'($urandom);
                bus.cpu_addr   = 16'($urandom);
                bus.cpu_wdata  = 8'($urandom);
                bus.dma_active = !v.dma;
            end
            idx++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/no_m_tick: no m_tick within 40 clocks, expected after %0d", v.name, v.exp_lat);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.dma_active = 1'b0; bus.mem_data_in = 8'h0; bus.mem_ready = 1'b1;
        bus2.cpu_req = 1'b1; bus2.cpu_write = 1'b0; bus2.cpu_addr = 16'hC000; bus2.cpu_wdata = 8'h0;
        bus2.dma_active = 1'b0; bus2.mem_data_in = 8'h42; bus2.mem_ready = 1'b1;

        vecs.push_back(mk("plain_read",     1, 0, 0, 16'hC000, 8'h3C, 8'h5A,   0, 1, 8'h5A, 0,  4));
        vecs.push_back(mk("write_setup",    1, 1, 0, 16'hD000, 8'hA5, 8'h99,   0, 1, 8'hFF, 0,  4));
        vecs.push_back(mk("wait2",          1, 0, 0, 16'hC001, 8'h11, 8'h3C,   2, 1, 8'h3C, 0,  6));
        vecs.push_back(mk("timeout_read",   1, 0, 0, 16'hC002, 8'h22, 8'hEE, 100, 1, 8'hFF, 1, 11));
        vecs.push_back(mk("ready_at_max",   1, 0, 0, 16'hC003, 8'h33, 8'h66,   7, 1, 8'h66, 0, 11));
        vecs.push_back(mk("wait6",          1, 0, 0, 16'hC004, 8'h44, 8'h67,   6, 1, 8'h67, 0, 10));
        vecs.push_back(mk("write_wait3",    1, 1, 0, 16'hD001, 8'h5C, 8'h00,   3, 1, 8'hFF, 0,  7));
        vecs.push_back(mk("write_timeout",  1, 1, 0, 16'hD002, 8'h6D, 8'h00, 100, 1, 8'hFF, 1, 11));
        vecs.push_back(mk("dma_block_read", 1, 0, 1, 16'h8000, 8'h77, 8'h12, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("dma_hram_read",  1, 0, 1, 16'hFF90, 8'h88, 8'h34,   0, 1, 8'h34, 0,  4));
        vecs.push_back(mk("dma_hram_lo",    1, 0, 1, 16'hFF80, 8'h89, 8'h56,   1, 1, 8'h56, 0,  5));
        vecs.push_back(mk("dma_hram_hi",    1, 0, 1, 16'hFFFE, 8'h8A, 8'h78,   0, 1, 8'h78, 0,  4));
        vecs.push_back(mk("dma_ffff",       1, 0, 1, 16'hFFFF, 8'h8B, 8'h9A, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("dma_ff7f",       1, 0, 1, 16'hFF7F, 8'h8C, 8'h9B, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("dma_block_write",1, 1, 1, 16'h8001, 8'hBB, 8'h00, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("idle",           0, 0, 0, 16'h1234, 8'hCC, 8'hDD, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("idle_dma",       0, 1, 1, 16'hFF90, 8'hCD, 8'hDE, 100, 0, 8'hFF, 0,  4));
        vecs.push_back(mk("read_after_idle",1, 0, 0, 16'h0000, 8'h01, 8'hA0,   0, 1, 8'hA0, 0,  4));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back(mk_exp(8'hFF, 1'b0, 4));
        @(negedge clk);
        check("reset/t_cycle", bus.t_cycle, 0);
        check("reset/mem_enable", bus.mem_enable, 1'b0);
        check("reset/mem_write", bus.mem_write, 1'b0);
        check("reset/m_tick_after", bus.m_tick, 1'b0);
        check("reset/bus_err", bus.bus_err, 1'b0);
        check("reset/mem_addr", bus.mem_addr, 16'h0000);
        check("reset/mem_data_out", bus.mem_data_out, 8'h00);
        check("reset/cpu_rdata", bus.cpu_rdata, 8'hFF);
        check("reset/clk_phi", bus.clk_phi, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while in WAIT, with mem_ready rising on that same clock: access must vanish.
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'hC0DE; bus.cpu_wdata = 8'h5E;
        bus.dma_active = 1'b0; bus.mem_data_in = 8'h24;
        sb.push_back(mk_exp(8'h24, 1'b0, 7));
        for (int i = 1; i <= 6; i++) begin
            bus.mem_ready = (i < 4);
            @(negedge clk);
            if (i == 6) begin
                check("rst_wait/t_cycle_held", bus.t_cycle, 3);
                check("rst_wait/mem_enable", bus.mem_enable, 1'b1);
            end
            @(posedge clk);
            #1;
            if (i == 1) bus.cpu_req = 1'b0;
        end
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("rst_wait/bus_err", bus.bus_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_addr = 16'h0000;
        last_wdata = 8'h00;
        sb.push_back(mk_exp(8'hFF, 1'b0, 4));
        @(negedge clk);
        check("rst_wait/next_t_cycle", bus.t_cycle, 0);
        check("rst_wait/next_mem_enable", bus.mem_enable, 1'b0);
        check("rst_wait/next_mem_write", bus.mem_write, 1'b0);
        check("rst_wait/next_m_tick", bus.m_tick, 1'b0);
        check("rst_wait/next_mem_addr", bus.mem_addr, 16'h0000);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        run_vec(mk("post_reset_read", 1, 0, 0, 16'hC100, 8'h10, 8'hB7, 0, 1, 8'hB7, 0, 4));
        check("sb/drained", sb.size(), 0);

        // T_CYCLES = 2 instance, continuous reads.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("t2/m_tick", bus2.m_tick, (i % 2) == 0);
            check("t2/t_cycle", bus2.t_cycle, (i - 1) % 2);
            check("t2/clk_phi", bus2.clk_phi, (i % 2) == 1);
            check("t2/mem_enable", bus2.mem_enable, 1'b1);
            if ((i % 2) == 0) check("t2/cpu_rdata", bus2.cpu_rdata, 8'h42);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
